arp_reply_tx: RTL and testbench
===============================

# arp_reply_tx

Builds and streams an Ethernet ARP reply frame, byte by byte, for each `send_arp_reply` pulse from the RX decision stage. It sits between the ARP/UDP decision logic and the MAC TX byte interface. It produces the frame from destination MAC through padding, and optionally the FCS. Preamble and SFD are added by the MAC.

## Interface
- `MY_MAC`, default 48'h02_00_00_00_00_01: our MAC address, used as the Ethernet source and the ARP sender hardware address.
- `MY_IP`, default 32'hC0A8_010A (192.168.1.10): ARP sender protocol address.
- `IFG_CYCLES`, default 12: idle cycles enforced after each frame's last byte is accepted.

- `clk50`  in  1  50 MHz clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `send_arp_reply`  in  1  one-cycle request pulse.
- `req_dst_mac`  in  48  requester MAC; sampled in the same cycle as `send_arp_reply`.
- `req_dst_ip`  in  32  requester IP; sampled in the same cycle as `send_arp_reply`.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_last`  out  1  final byte of the frame; qualified by `tx_valid`.
- `tx_ready`  in  1  MAC accepts the byte when `tx_valid && tx_ready`.
- `busy`  out  1  high in SEND and IFG states.
- `req_dropped`  out  1  one-cycle pulse when a request is discarded.
- `frames_sent`  out  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE → SEND on a request, or on a pending request.
  - SEND → IFG when the last byte is accepted.
  - IFG → IDLE after `IFG_CYCLES` cycles.
- Request capture:
  - In IDLE, a pulse latches `req_dst_mac`/`req_dst_ip` into the active registers.
  - In SEND or IFG, a pulse goes into a one-deep pending slot.
  - If the pending slot is already full, the new request is discarded, `req_dropped` pulses, and the held request is kept.
- On leaving IFG with the pending slot full, the pending request moves to active and the block enters SEND directly. IDLE is skipped for 0 cycles.
- Byte index counter `idx` starts at 0 and advances only on handshake. Frame layout (multi-byte fields MSB first):
  - 0–5: `req_dst_mac`
  - 6–11: `MY_MAC`
  - 12–13: 0x0806
  - 14–15: 0x0001
  - 16–17: 0x0800
  - 18: 0x06
  - 19: 0x04
  - 20–21: 0x0002
  - 22–27: `MY_MAC`
  - 28–31: `MY_IP`
  - 32–37: `req_dst_mac`
  - 38–41: `req_dst_ip`
  - 42–59: 0x00 padding
- Last byte index is 59, or 63 with the FCS feature compiled in.
- `frames_sent` increments on the cycle the last byte is accepted.

## Timing
- Reset values:
  - `tx_valid`, `tx_last`, `busy`, `req_dropped` = 0
  - `tx_data` = 0x00
  - `frames_sent` = 0
  - active and pending registers cleared; pending slot empty; state IDLE.
- Latency: a pulse sampled at edge N in IDLE gives `tx_valid` = 1 with byte 0 (`req_dst_mac[47:40]`) after edge N+1, and `busy` = 1 from the same cycle.
- Handshake:
  - Once asserted, `tx_valid` stays high until the last byte is accepted, with no gaps.
  - `tx_data` and `tx_last` are held stable while `tx_valid && !tx_ready`.
  - The next byte is presented the cycle after acceptance.
- With `tx_ready` held high, a 60-byte frame occupies exactly 60 consecutive `tx_valid` cycles.
- IFG: `tx_valid` = 0 and `busy` = 1 for exactly `IFG_CYCLES` cycles after the last accept.
- A request pulse in the same cycle the IFG ends counts as a pending request.
- Reset mid-frame: all outputs return to their reset values on the next edge. The frame is truncated and the pending request is lost.

## Configuration
- `ARP_TX_FCS_EN` defined:
  - The block computes CRC-32 over bytes 0–59 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF).
  - It appends the result as bytes 60–63, least-significant byte first; `tx_last` is on byte 63.
  - The CRC updates only on accepted bytes.
- `ARP_TX_FCS_EN` undefined: the frame ends at byte 59 and the MAC appends the FCS. No CRC logic is present.

## Test plan
- **Single reply:** pulse with `req_dst_mac` = 0x001122334455 and `req_dst_ip` = 0xC0A80164, `tx_ready` held at 1.
  - 60 bytes, byte 12–13 = 08 06, byte 21 = 02, bytes 38–41 = C0 A8 01 64.
  - `tx_last` on byte 59; `frames_sent` = 1.
- **Backpressure:** toggle `tx_ready` 1/0 every cycle.
  - `tx_data` and `tx_last` are stable during stalls.
  - The byte sequence matches the single-reply case; 120 cycles from the first valid to the last accept.
- **Queued request:** a second pulse (MAC 0xAABBCCDDEEFF) arrives at byte 10 of the first frame.
  - The second frame starts exactly `IFG_CYCLES` after the first frame's last accept, with destination MAC AA..FF; no `req_dropped`.
- **Overflow:** three pulses during one frame.
  - One `req_dropped` pulse on the third; exactly two frames total, the second carrying the second request.
- **Reset mid-frame:** assert `rst_n` = 0 at byte 30.
  - `tx_valid` = 0 on the next cycle; after release, no output until a new pulse.
- **FCS (ARP_TX_FCS_EN):** single-reply stimulus.
  - 64 bytes; bytes 60–63 equal the software CRC-32 model of bytes 0–59; the receiver-side residue check passes.

Source files
------------

// File: rtl/arp_reply_tx.sv
// Builds an Ethernet ARP reply and streams it byte by byte to the MAC TX interface.
// Define ARP_TX_FCS_EN to append the CRC-32 FCS (bytes 60-63) inside this block.
module arp_reply_tx #(
  parameter logic [47:0] MY_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [31:0] MY_IP      = 32'hC0A8_010A,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        send_arp_reply,
  input  logic [47:0] req_dst_mac,
  input  logic [31:0] req_dst_ip,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        req_dropped,
  output logic [15:0] frames_sent
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_IFG  = 2'd2;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_END = IFG_W'(IFG_CYCLES - 1);
`ifdef ARP_TX_FCS_EN
  localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = 6'd59;
`endif

  function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [IDX_W-1:0] k);
    logic [47:0] s;
    s = v << {k, 3'b000};
    return s[47:40];
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input logic [IDX_W-1:0] k);
    logic [31:0] s;
    s = v << {k, 3'b000};
    return s[31:24];
  endfunction

  // Frame content for bytes 0-59; multi-byte fields go out MSB first.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i,
                                            input logic [47:0] mac, input logic [31:0] ip);
    logic [7:0] b;
    b = 8'h00;
    if (i < 6'd6)       b = byte_of48(mac, i);
    else if (i < 6'd12) b = byte_of48(MY_MAC, i - 6'd6);
    else if (i < 6'd22) begin
      case (i)
        6'd12, 6'd16: b = 8'h08;
        6'd13, 6'd18: b = 8'h06;
        6'd15:        b = 8'h01;
        6'd19:        b = 8'h04;
        6'd21:        b = 8'h02;
        default:      b = 8'h00;
      endcase
    end
    else if (i < 6'd28) b = byte_of48(MY_MAC, i - 6'd22);
    else if (i < 6'd32) b = byte_of32(MY_IP, i - 6'd28);
    else if (i < 6'd38) b = byte_of48(mac, i - 6'd32);
    else if (i < 6'd42) b = byte_of32(ip, i - 6'd38);
    return b;
  endfunction

`ifdef ARP_TX_FCS_EN
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  logic [31:0] crc, crc_nxt, crc_upd, fcs;
`endif

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, idx_inc;
  logic [47:0]      act_mac, act_mac_nxt, pend_mac, pend_mac_nxt;
  logic [31:0]      act_ip, act_ip_nxt, pend_ip, pend_ip_nxt;
  logic             pend_full, pend_full_nxt;
  logic [IFG_W-1:0] ifg_cnt, ifg_cnt_nxt;
  logic [7:0]       data_nxt, next_byte;
  logic             valid_nxt, last_nxt, busy_nxt, dropped_nxt;
  logic [15:0]      frames_nxt;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    act_mac_nxt   = act_mac;
    act_ip_nxt    = act_ip;
    pend_mac_nxt  = pend_mac;
    pend_ip_nxt   = pend_ip;
    pend_full_nxt = pend_full;
    ifg_cnt_nxt   = ifg_cnt;
    data_nxt      = tx_data;
    valid_nxt     = tx_valid;
    last_nxt      = tx_last;
    busy_nxt      = busy;
    dropped_nxt   = 1'b0;
    frames_nxt    = frames_sent;
    idx_inc       = idx + 6'd1;
    next_byte     = frame_byte(idx_inc, act_mac, act_ip);
`ifdef ARP_TX_FCS_EN
    crc_nxt = crc;
    crc_upd = crc_byte(crc, tx_data);
    // Byte 59's contribution is not yet in crc when byte 60 is prepared.
    fcs     = ~((idx == 6'd59) ? crc_upd : crc);
    if (idx_inc >= 6'd60) next_byte = 8'(fcs >> {idx_inc[1:0], 3'b000});
`endif

    if (send_arp_reply && (state != ST_IDLE)) begin
      if (pend_full) begin
        dropped_nxt = 1'b1;
      end else begin
        pend_mac_nxt  = req_dst_mac;
        pend_ip_nxt   = req_dst_ip;
        pend_full_nxt = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (send_arp_reply) begin
          act_mac_nxt = req_dst_mac;
          act_ip_nxt  = req_dst_ip;
          idx_nxt     = '0;
          state_nxt   = ST_SEND;
`ifdef ARP_TX_FCS_EN
          crc_nxt = 32'hFFFF_FFFF;
`endif
        end
      end
      ST_SEND: begin
        if (!tx_valid) begin
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          last_nxt  = 1'b0;
          data_nxt  = frame_byte('0, act_mac, act_ip);
        end else if (tx_ready) begin
`ifdef ARP_TX_FCS_EN
          if (idx < 6'd60) crc_nxt = crc_upd;
`endif
          if (tx_last) begin
            state_nxt   = ST_IFG;
            ifg_cnt_nxt = '0;
            valid_nxt   = 1'b0;
            last_nxt    = 1'b0;
            data_nxt    = 8'h00;
            frames_nxt  = frames_sent + 16'd1;
          end else begin
            idx_nxt  = idx_inc;
            data_nxt = next_byte;
            last_nxt = (idx_inc == LAST_IDX);
          end
        end
      end
      ST_IFG: begin
        if (ifg_cnt == IFG_END) begin
          if (pend_full || send_arp_reply) begin
            // Queued (or same-cycle) request goes straight out, skipping IDLE.
            state_nxt = ST_SEND;
            idx_nxt   = '0;
            valid_nxt = 1'b1;
            last_nxt  = 1'b0;
`ifdef ARP_TX_FCS_EN
            crc_nxt = 32'hFFFF_FFFF;
`endif
            if (pend_full) begin
              act_mac_nxt   = pend_mac;
              act_ip_nxt    = pend_ip;
              data_nxt      = frame_byte('0, pend_mac, pend_ip);
              dropped_nxt   = 1'b0;
              pend_full_nxt = send_arp_reply;
              if (send_arp_reply) begin
                pend_mac_nxt = req_dst_mac;
                pend_ip_nxt  = req_dst_ip;
              end
            end else begin
              act_mac_nxt   = req_dst_mac;
              act_ip_nxt    = req_dst_ip;
              data_nxt      = frame_byte('0, req_dst_mac, req_dst_ip);
              pend_full_nxt = 1'b0;
            end
          end else begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          ifg_cnt_nxt = ifg_cnt + IFG_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      act_mac     <= '0;
      act_ip      <= '0;
      pend_mac    <= '0;
      pend_ip     <= '0;
      pend_full   <= 1'b0;
      ifg_cnt     <= '0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b0;
      busy        <= 1'b0;
      req_dropped <= 1'b0;
      frames_sent <= 16'd0;
`ifdef ARP_TX_FCS_EN
      crc         <= 32'hFFFF_FFFF;
`endif
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      act_mac     <= act_mac_nxt;
      act_ip      <= act_ip_nxt;
      pend_mac    <= pend_mac_nxt;
      pend_ip     <= pend_ip_nxt;
      pend_full   <= pend_full_nxt;
      ifg_cnt     <= ifg_cnt_nxt;
      tx_data     <= data_nxt;
      tx_valid    <= valid_nxt;
      tx_last     <= last_nxt;
      busy        <= busy_nxt;
      req_dropped <= dropped_nxt;
      frames_sent <= frames_nxt;
`ifdef ARP_TX_FCS_EN
      crc         <= crc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Randomized self-checking bench for arp_reply_tx; expected frames come from a byte-array model.
`timescale 1ns/1ps
module tb_arp_reply_tx;
  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] MY_IP  = 32'hC0A8_010A;
  localparam int IFG = 12;
`ifdef ARP_TX_FCS_EN
  localparam int FLEN = 64;
`else
  localparam int FLEN = 60;
`endif

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        send_arp_reply = 1'b0;
  logic [47:0] req_dst_mac = '0;
  logic [31:0] req_dst_ip = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy, req_dropped;
  logic        tx_ready = 1'b0;
  logic [15:0] frames_sent;

  arp_reply_tx #(.MY_MAC(MY_MAC), .MY_IP(MY_IP), .IFG_CYCLES(IFG)) dut (
    .clk50(clk50), .rst_n(rst_n), .send_arp_reply(send_arp_reply),
    .req_dst_mac(req_dst_mac), .req_dst_ip(req_dst_ip),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .req_dropped(req_dropped), .frames_sent(frames_sent)
  );

  always #10 clk50 = ~clk50;

  int n_tests = 0;
  int n_fail = 0;
  int exp_frames = 0;
  logic [7:0] exp_b [64];
  logic [7:0] got_b [64];
  int got_n, vcycles, stall_bad, gaps, drops;
  int sched_at [4];
  logic [47:0] sched_mac [4];
  logic [31:0] sched_ip [4];
  int sched_n = 0;

  task automatic tick;
    @(posedge clk50);
    #1;
  endtask

`ifdef ARP_TX_FCS_EN
  // MSB-first CRC-32 on bit-reversed bytes; returns the raw register.
  function automatic logic [31:0] crc_reg(input logic [7:0] a [64], input int n);
    logic [31:0] c;
    logic [7:0] rb;
    logic top;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) rb[j] = a[i][7-j];
      for (int j = 7; j >= 0; j--) begin
        top = c[31] ^ rb[j];
        c = c << 1;
        if (top) c = c ^ 32'h04C1_1DB7;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction
`endif

  task automatic put(input logic [47:0] v, input int n, inout int p);
    for (int k = 0; k < n; k++) begin
      exp_b[p] = v[8*(n-1-k) +: 8];
      p++;
    end
  endtask

  task automatic build_frame(input logic [47:0] mac, input logic [31:0] ip);
    int p;
    p = 0;
    put(mac, 6, p);           put(MY_MAC, 6, p);
    put(48'h0806, 2, p);      put(48'h0001, 2, p);
    put(48'h0800, 2, p);      put(48'h06, 1, p);
    put(48'h04, 1, p);        put(48'h0002, 2, p);
    put(MY_MAC, 6, p);        put({16'h0, MY_IP}, 4, p);
    put(mac, 6, p);           put({16'h0, ip}, 4, p);
    while (p < 64) begin exp_b[p] = 8'h00; p++; end
`ifdef ARP_TX_FCS_EN
    begin
      logic [31:0] f;
      f = rev32(crc_reg(exp_b, 60)) ^ 32'hFFFF_FFFF;
      for (int k = 0; k < 4; k++) exp_b[60+k] = f[8*k +: 8];
    end
`endif
  endtask

  function automatic int first_diff(input int n);
    for (int i = 0; i < n; i++) if (got_b[i] !== exp_b[i]) return i;
    return -1;
  endfunction

  task automatic pulse(input logic [47:0] mac, input logic [31:0] ip);
    send_arp_reply = 1'b1;
    req_dst_mac = mac;
    req_dst_ip = ip;
    tick;
    send_arp_reply = 1'b0;
  endtask

  // Gathers one frame; mode 0 = ready high, 1 = toggle starting low, 2 = random.
  task automatic collect(input int mode, output bit to);
    int cyc, si;
    bit have_prev, started, phase, done, rdy;
    logic [7:0] pd;
    logic pl;
    got_n = 0; vcycles = 0; stall_bad = 0; gaps = 0;
    to = 0; have_prev = 0; started = 0; phase = 0; done = 0; cyc = 0; si = 0;
    pd = 8'h00; pl = 1'b0;
    while (!done) begin
      if (cyc >= 2000) begin to = 1; break; end
      send_arp_reply = 1'b0;
      if (req_dropped === 1'b1) drops++;
      if (tx_valid === 1'b1) begin
        if (have_prev && (tx_data !== pd || tx_last !== pl)) stall_bad++;
        if (!started) begin started = 1; phase = 0; end
        vcycles++;
        case (mode)
          0: rdy = 1;
          1: rdy = phase;
          default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        phase = ~phase;
        if (si < sched_n && sched_at[si] == got_n) begin
          send_arp_reply = 1'b1;
          req_dst_mac = sched_mac[si];
          req_dst_ip = sched_ip[si];
          si++;
        end
        if (rdy) begin
          if (got_n < 64) got_b[got_n] = tx_data;
          got_n++;
          if (tx_last === 1'b1 || got_n >= 64) done = 1;
          have_prev = 0;
        end else begin
          have_prev = 1; pd = tx_data; pl = tx_last;
        end
        tx_ready = rdy;
      end else begin
        if (started) gaps++;
        have_prev = 0;
        tx_ready = 1'b0;
      end
      tick;
      cyc++;
    end
    send_arp_reply = 1'b0;
    sched_n = 0;
  endtask

  task automatic wait_idle;
    int c;
    c = 0;
    while ((busy !== 1'b0 || tx_valid !== 1'b0) && c < 300) begin tick; c++; end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    n_tests++;
    if ({tx_valid, tx_last, busy, req_dropped} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {tx_valid, tx_last, busy, req_dropped});
    end
    n_tests++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", tx_data); end
    n_tests++;
    if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d expected 0", frames_sent); end
    rst_n = 1'b1;
    repeat (20) tick;
    n_tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: valid %b busy %b expected 0 0", tx_valid, busy);
    end
  endtask

  task automatic check_frame(input string nm, input bit to, input int exp_vc);
    int d;
    n_tests++;
    if (to) begin n_fail++; $display("FAIL %s_timeout: no complete frame within budget", nm); end
    d = first_diff(FLEN);
    n_tests++;
    if (got_n != FLEN || d >= 0) begin
      n_fail++;
      $display("FAIL %s_bytes: length %0d expected %0d, first bad byte %0d got %h expected %h",
               nm, got_n, FLEN, d, (d >= 0) ? got_b[d] : 8'h00, (d >= 0) ? exp_b[d] : 8'h00);
    end
    n_tests++;
    if (stall_bad != 0 || gaps != 0) begin
      n_fail++; $display("FAIL %s_handshake: unstable stalls %0d valid gaps %0d expected 0 0", nm, stall_bad, gaps);
    end
    if (exp_vc > 0) begin
      n_tests++;
      if (vcycles != exp_vc) begin n_fail++; $display("FAIL %s_cycles: got %0d expected %0d", nm, vcycles, exp_vc); end
    end
    n_tests++;
    if (frames_sent !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL %s_count: frames_sent %0d expected %0d", nm, frames_sent, exp_frames);
    end
  endtask

  task automatic test_single;
    bit to;
    build_frame(48'h0011_2233_4455, 32'hC0A8_0164);
    pulse(48'h0011_2233_4455, 32'hC0A8_0164);
    n_tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: valid %b busy %b expected 0 0", tx_valid, busy);
    end
    tick;
    n_tests++;
    if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL latency_first: valid %b busy %b data %h expected 1 1 00", tx_valid, busy, tx_data);
    end
    drops = 0;
    collect(0, to);
    exp_frames++;
    check_frame("single", to, FLEN);
    n_tests++;
    if ({got_b[12], got_b[13], got_b[21]} !== 24'h080602) begin
      n_fail++; $display("FAIL single_fields: got %h %h %h expected 08 06 02", got_b[12], got_b[13], got_b[21]);
    end
    n_tests++;
    if ({got_b[38], got_b[39], got_b[40], got_b[41]} !== 32'hC0A8_0164) begin
      n_fail++; $display("FAIL single_tpa: got %h%h%h%h expected c0a80164", got_b[38], got_b[39], got_b[40], got_b[41]);
    end
`ifdef ARP_TX_FCS_EN
    begin
      logic [31:0] f;
      f = rev32(crc_reg(got_b, 60)) ^ 32'hFFFF_FFFF;
      n_tests++;
      if ({got_b[63], got_b[62], got_b[61], got_b[60]} !== f) begin
        n_fail++; $display("FAIL fcs_value: got %h%h%h%h expected %h", got_b[63], got_b[62], got_b[61], got_b[60], f);
      end
      n_tests++;
      if (rev32(crc_reg(got_b, 64)) !== 32'hDEBB_20E3) begin
        n_fail++; $display("FAIL fcs_residue: got %h expected debb20e3", rev32(crc_reg(got_b, 64)));
      end
    end
`endif
    wait_idle;
  endtask

  task automatic test_backpressure;
    bit to;
    build_frame(48'h0011_2233_4455, 32'hC0A8_0164);
    pulse(48'h0011_2233_4455, 32'hC0A8_0164);
    collect(1, to);
    exp_frames++;
    check_frame("backpressure", to, 2 * FLEN);
    wait_idle;
  endtask

  task automatic gap_check(input string nm);
    int g, bad;
    g = 0; bad = 0;
    while (tx_valid !== 1'b1 && g < 200) begin
      if (busy !== 1'b1) bad++;
      if (req_dropped === 1'b1) drops++;
      g++;
      tick;
    end
    n_tests++;
    if (g != IFG || bad != 0) begin
      n_fail++; $display("FAIL %s_ifg: gap %0d busy-low %0d expected %0d 0", nm, g, bad, IFG);
    end
  endtask

  task automatic test_queued;
    bit to;
    logic [31:0] ip_b;
    ip_b = $urandom;
    drops = 0;
    sched_at[0] = 10; sched_mac[0] = 48'hAABB_CCDD_EEFF; sched_ip[0] = ip_b; sched_n = 1;
    build_frame(48'h0011_2233_4455, 32'hC0A8_0164);
    pulse(48'h0011_2233_4455, 32'hC0A8_0164);
    collect(0, to);
    exp_frames++;
    check_frame("queued_first", to, FLEN);
    gap_check("queued");
    build_frame(48'hAABB_CCDD_EEFF, ip_b);
    collect(0, to);
    exp_frames++;
    check_frame("queued_second", to, FLEN);
    n_tests++;
    if (drops != 0) begin n_fail++; $display("FAIL queued_drop: got %0d expected 0", drops); end
    wait_idle;
  endtask

  task automatic test_overflow;
    bit to;
    int extra;
    drops = 0;
    sched_at[0] = 5;  sched_mac[0] = 48'h1010_2020_3030; sched_ip[0] = 32'h0A00_0005;
    sched_at[1] = 10; sched_mac[1] = 48'h4040_5050_6060; sched_ip[1] = 32'h0A00_0006;
    sched_n = 2;
    build_frame(48'h0123_4567_89AB, 32'h0A00_0004);
    pulse(48'h0123_4567_89AB, 32'h0A00_0004);
    collect(2, to);
    exp_frames++;
    check_frame("overflow_first", to, 0);
    gap_check("overflow");
    build_frame(48'h1010_2020_3030, 32'h0A00_0005);
    collect(0, to);
    exp_frames++;
    check_frame("overflow_second", to, FLEN);
    extra = 0;
    for (int c = 0; c < 200; c++) begin
      if (tx_valid === 1'b1) extra++;
      if (req_dropped === 1'b1) drops++;
      tick;
    end
    n_tests++;
    if (extra != 0) begin n_fail++; $display("FAIL overflow_third: valid cycles %0d expected 0", extra); end
    n_tests++;
    if (drops != 1) begin n_fail++; $display("FAIL overflow_drops: got %0d expected 1", drops); end
  endtask

  task automatic test_random;
    bit to;
    logic [47:0] mac;
    logic [31:0] ip;
    for (int n = 0; n < 6; n++) begin
      mac = {16'($urandom), 32'($urandom)};
      ip = $urandom;
      build_frame(mac, ip);
      pulse(mac, ip);
      collect(2, to);
      exp_frames++;
      check_frame("random", to, 0);
      wait_idle;
    end
  endtask

  task automatic test_reset_mid;
    int cnt, c, seen;
    pulse(48'h00AA_00BB_00CC, 32'hC0A8_0102);
    cnt = 0; c = 0;
    tx_ready = 1'b1;
    while (c < 500) begin
      send_arp_reply = 1'b0;
      if (tx_valid === 1'b1) begin
        if (cnt == 30) break;
        if (cnt == 20) begin
          send_arp_reply = 1'b1;
          req_dst_mac = 48'h0D0D_0D0D_0D0D;
          req_dst_ip = 32'h0D0D_0D0D;
        end
        cnt++;
      end
      tick;
      c++;
    end
    send_arp_reply = 1'b0;
    n_tests++;
    if (cnt != 30) begin n_fail++; $display("FAIL reset_mid_reach: bytes %0d expected 30", cnt); end
    rst_n = 1'b0;
    tick;
    exp_frames = 0;
    n_tests++;
    if ({tx_valid, tx_last, busy, req_dropped} !== 4'b0000 || tx_data !== 8'h00 || frames_sent !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: flags %b data %h frames %0d expected 0000 00 0",
               {tx_valid, tx_last, busy, req_dropped}, tx_data, frames_sent);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      tick;
      if (tx_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_mid_quiet: active cycles %0d expected 0", seen); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_queued;
    test_overflow;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
